// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer write port plus transmitter handshake for uart_tx_fifo.
// Optional UART_TXF_OVF_CNT_EN adds the ovf_count status signal.
`default_nettype none

interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  wr_data;
  logic        wr_en;
  logic        flush;
  logic        full;
  logic        empty;
  logic [AW:0] level;
  logic        overflow;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
`ifdef UART_TXF_OVF_CNT_EN
  logic [15:0] ovf_count;

  modport master (
    output wr_data, wr_en, flush, tx_busy,
    input  full, empty, level, overflow, tx_data, tx_start, ovf_count
  );
  modport slave (
    input  wr_data, wr_en, flush, tx_busy,
    output full, empty, level, overflow, tx_data, tx_start, ovf_count
  );
`else
  modport master (
    output wr_data, wr_en, flush, tx_busy,
    input  full, empty, level, overflow, tx_data, tx_start
  );
  modport slave (
    input  wr_data, wr_en, flush, tx_busy,
    output full, empty, level, overflow, tx_data, tx_start
  );
`endif
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo: byte FIFO that drains one byte at a time into a UART transmitter.
// Optional macro UART_TXF_OVF_CNT_EN adds a saturating dropped-write counter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  uart_tx_fifo_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [1:0]  state;
  logic [7:0]  tx_data_r;
  logic        tx_start_r;
  logic        overflow_r;
  logic        fifo_empty;
  logic        fifo_full;
  logic        do_write;
  logic        do_drop;
  logic        do_pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Flush overrides both the write and the pop; full uses pre-edge pointers.
  assign do_write = bus.wr_en && !fifo_full && !bus.flush;
  assign do_drop  = bus.wr_en &&  fifo_full && !bus.flush;
  assign do_pop   = (state == S_IDLE) && !fifo_empty && !bus.tx_busy && !bus.flush;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr[AW-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= do_drop;
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_write) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Drain controller; an in-flight byte runs to completion regardless of flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tx_data_r  <= 8'h00;
      tx_start_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (do_pop) begin
            tx_data_r  <= mem[rd_ptr[AW-1:0]];
            tx_start_r <= 1'b1;
            state      <= S_ARM;
          end
        end
        S_ARM: begin
          tx_start_r <= 1'b0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.tx_busy) state <= S_IDLE;
        end
        default: begin
          tx_start_r <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UART_TXF_OVF_CNT_EN
  logic [15:0] ovf_count_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count_r <= 16'h0000;
    end else if (bus.flush) begin
      ovf_count_r <= 16'h0000;
    end else if (do_drop && (ovf_count_r != 16'hFFFF)) begin
      ovf_count_r <= ovf_count_r + 16'h0001;
    end
  end

  assign bus.ovf_count = ovf_count_r;
`endif

  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.level    = wr_ptr - rd_ptr;
  assign bus.overflow = overflow_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.tx_start = tx_start_r;

endmodule

`default_nettype wire
